// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous instruction
// memory and captures the fetched word into the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_plus4,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [ADDR_W-1:0]  id_pc4_q, id_pc4_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  target_aligned;
  logic               cnt_full;

  // Wraps modulo 2^ADDR_W by construction of the sized add.
  assign pc_plus4       = pc_q + ADDR_W'(4);
  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};
  assign cnt_full       = &cnt_q;

  // Priority: branch redirect (flush) beats stall, which beats normal fetch.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    if (branch_taken) begin
      pc_d       = target_aligned;
      id_pc_d    = '0;
      id_pc4_d   = '0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_plus4;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_plus4;
      id_instr_d = imem_rdata;
      id_valid_d = 1'b1;
      if (!cnt_full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_instr    = id_instr_q;
  assign if_id_valid    = id_valid_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, run, stall, branch flush, wrap,
// reset mid-stall and counter saturation (narrow-counter instance).
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic        s_stall;
  logic        s_branch;
  logic [31:0] s_target;
  logic [31:0] s_imem_addr;
  logic [31:0] s_imem_rdata;
  logic [31:0] s_pc;
  logic [31:0] s_pc4;
  logic [31:0] s_instr;
  logic        s_valid;
  logic [3:0]  s_count;

  int errors;
  int checks;

  // Instruction memory model: each word equals its address.
  assign imem_rdata   = imem_addr;
  assign s_imem_rdata = s_imem_addr;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  if_fetch_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(s_stall), .branch_taken(s_branch),
    .branch_target(s_target), .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
    .if_id_pc(s_pc), .if_id_pc_plus4(s_pc4), .if_id_instr(s_instr),
    .if_id_valid(s_valid), .fetch_count(s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic e_valid, input logic [31:0] e_cnt);
    check_eq({tag, ".imem_addr"}, imem_addr, e_addr);
    check_eq({tag, ".if_id_pc"}, if_id_pc, e_pc);
    check_eq({tag, ".if_id_instr"}, if_id_instr, e_instr);
    check_eq({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check_eq({tag, ".fetch_count"}, fetch_count, e_cnt);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    s_stall = 1'b0; s_branch = 1'b0; s_target = '0;

    // 1. reset and run
    step(); step();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check_eq("reset.pc_plus4", if_id_pc_plus4, 32'h0);
    rst = 1'b0;
    step(); check_ifid("run0", 32'h4, 32'h0, 32'h0, 1'b1, 32'd1);
    check_eq("run0.pc_plus4", if_id_pc_plus4, 32'h4);
    step(); check_ifid("run1", 32'h8, 32'h4, 32'h4, 1'b1, 32'd2);
    step(); check_ifid("run2", 32'hC, 32'h8, 32'h8, 1'b1, 32'd3);
    step(); check_ifid("run3", 32'h10, 32'hC, 32'hC, 1'b1, 32'd4);

    // 2. stall hold for 3 cycles at pc=0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_ifid("stall", 32'h10, 32'hC, 32'hC, 1'b1, 32'd4);
    end
    stall = 1'b0;
    step(); check_ifid("unstall0", 32'h14, 32'h10, 32'h10, 1'b1, 32'd5);
    step(); check_ifid("unstall1", 32'h18, 32'h14, 32'h14, 1'b1, 32'd6);
    step(); step();
    check_ifid("run_to_20", 32'h20, 32'h1C, 32'h1C, 1'b1, 32'd8);

    // 3. branch flush with misaligned target
    branch_taken = 1'b1; branch_target = 32'h103;
    step(); check_ifid("branch", 32'h100, 32'h0, 32'h0, 1'b0, 32'd8);
    check_eq("branch.pc_plus4", if_id_pc_plus4, 32'h0);
    branch_taken = 1'b0;
    step(); check_ifid("target", 32'h104, 32'h100, 32'h100, 1'b1, 32'd9);
    check_eq("target.pc_plus4", if_id_pc_plus4, 32'h104);

    // 4. branch with stall, then back-to-back branches
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step(); check_ifid("br_stall", 32'h40, 32'h0, 32'h0, 1'b0, 32'd9);
    stall = 1'b0; branch_target = 32'h80;
    step(); check_ifid("b2b0", 32'h80, 32'h0, 32'h0, 1'b0, 32'd9);
    branch_target = 32'hC0;
    step(); check_ifid("b2b1", 32'hC0, 32'h0, 32'h0, 1'b0, 32'd9);
    branch_taken = 1'b0;
    step(); check_ifid("b2b_land", 32'hC4, 32'hC0, 32'hC0, 1'b1, 32'd10);

    // 5. wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step(); check_ifid("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd10);
    branch_taken = 1'b0;
    step(); check_ifid("wrap0", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd11);
    check_eq("wrap0.pc_plus4", if_id_pc_plus4, 32'h0);
    step(); check_ifid("wrap1", 32'h4, 32'h0, 32'h0, 1'b1, 32'd12);
    check_eq("wrap1.pc_plus4", if_id_pc_plus4, 32'h4);

    // reset during an active stall
    stall = 1'b1;
    step(); check_ifid("pre_rst_stall", 32'h4, 32'h0, 32'h0, 1'b1, 32'd12);
    rst = 1'b1;
    step(); check_ifid("rst_mid_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check_eq("rst_mid_stall.pc_plus4", if_id_pc_plus4, 32'h0);
    check_eq("rst_mid_stall.sat_count", {28'd0, s_count}, 32'd0);
    rst = 1'b0; stall = 1'b0;

    // 6. 4-bit counter saturates at 15; wide counter keeps counting
    for (int i = 1; i <= 20; i++) begin
      step();
      check_eq("sat_count", {28'd0, s_count}, (i > 15) ? 32'd15 : 32'(i));
    end
    check_eq("wide_count", fetch_count, 32'd20);
    check_eq("wide_addr", imem_addr, 32'd80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
